// File: rtl/obi_interconnect_pkg.sv
// ============================================================================
// obi_interconnect_pkg
// ----------------------------------------------------------------------------
// Shared definitions for the OBI system bus interconnect.
//   OBI_ADDR_W   : width of an OBI address bus
//   master_idx_t : widest master index the interconnect is built for; each
//                  arbiter instance uses the low MASTER_BITS of it
//   arb_state_e  : per-slave arbiter states (idle search / address locked)
// ============================================================================
package obi_interconnect_pkg;

    localparam int OBI_ADDR_W       = 32;
    localparam int MASTER_IDX_MAX_W = 8;

    typedef logic [MASTER_IDX_MAX_W-1:0] master_idx_t;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/obi_arb_id_fifo.sv
// ============================================================================
// obi_arb_id_fifo
// ----------------------------------------------------------------------------
// In-order FIFO of master indices for the per-slave arbiter. Each granted
// transaction pushes the granting master's index; each accepted slave
// response pops it. Built as a shift register so the head is always a
// register output (entry 0) and can drive the response demux without a
// read-pointer mux in front of it.
//
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push          : write push_data (ignored while full)
//   push_data     : master index to enqueue
//   pop           : drop the head entry (ignored while empty)
//   head          : oldest entry; zero when empty
//   full, empty   : occupancy flags
//   count         : number of stored entries
// ============================================================================
module obi_arb_id_fifo #(
    parameter int WIDTH = 2,
    parameter int DEPTH = 2
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [CNT_W-1:0] cnt;
    logic             push_ok;
    logic             pop_ok;
    logic [CNT_W-1:0] wr_pos;

    assign full    = (cnt == CNT_W'(DEPTH));
    assign empty   = (cnt == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;

    // When a pop shifts everything down in the same cycle, the new entry
    // lands one slot lower than the current occupancy.
    assign wr_pos  = pop_ok ? (cnt - CNT_W'(1)) : cnt;

    // Storage and occupancy. A pop shifts the queue towards entry 0 and
    // fills the vacated top slot with zero, so an empty FIFO always shows a
    // zero head. A push in the same cycle overrides the shifted value at
    // its write position because it is assigned later in the block.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (pop_ok) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    mem[i] <= mem[i+1];
                end
                mem[DEPTH-1] <= '0;
            end
            if (push_ok) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (wr_pos == CNT_W'(i)) begin
                        mem[i] <= push_data;
                    end
                end
            end
            cnt <= cnt + CNT_W'(push_ok) - CNT_W'(pop_ok);
        end
    end

    assign head  = mem[0];
    assign count = cnt;

endmodule

// File: rtl/obi_rr_slave_arbiter.sv
// ============================================================================
// obi_rr_slave_arbiter
// ----------------------------------------------------------------------------
// Per-slave arbiter of the OBI interconnect. MASTERS requesters share one
// slave port. A round-robin search picks the next master whose request
// decodes to this slave; once the request is shown to the slave without a
// grant, the choice is locked until the handshake completes. Granted master
// indices are queued in order so every rvalid is routed back to the master
// that issued the matching request.
//
// Configuration:
//   OBI_ARB_FIXED_PRIO_EN : when defined, the round-robin pointer is removed
//                           and the lowest-index requester always wins the
//                           idle search (locking and response tracking stay
//                           the same).
//
// Ports:
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   master_req_i       : OBI req per master
//   master_addr_i      : OBI addr per master
//   slave_addr_mask_i  : decode mask for this slave
//   slave_addr_base_i  : decode base; match when (addr & mask) == base
//   slave_gnt_i        : slave address-phase grant
//   slave_rvalid_i     : slave response valid
//   slave_req_o        : req forwarded to the slave
//   master_sel_int_o   : index of the master owning the address phase
//   master_sel_vec_o   : one-hot of master_sel_int_o, zero when none
//   granted_master_o   : a master is selected
//   master_gnt_o       : slave grant routed to the selected master
//   rsp_sel_int_o      : master owed the next response (FIFO head)
//   master_rvalid_o    : slave rvalid routed to rsp_sel_int_o
//   outstanding_o      : number of granted transactions awaiting rvalid
// ============================================================================
module obi_rr_slave_arbiter
    import obi_interconnect_pkg::*;
#(
    parameter int MASTERS         = 3,
    parameter int MASTER_BITS     = (MASTERS == 1) ? 1 : $clog2(MASTERS),
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [MASTERS-1:0]                     master_req_i,
    input  logic [MASTERS-1:0][OBI_ADDR_W-1:0]     master_addr_i,
    input  logic [OBI_ADDR_W-1:0]                  slave_addr_mask_i,
    input  logic [OBI_ADDR_W-1:0]                  slave_addr_base_i,
    input  logic                                   slave_gnt_i,
    input  logic                                   slave_rvalid_i,
    output logic                                   slave_req_o,
    output logic [MASTER_BITS-1:0]                 master_sel_int_o,
    output logic [MASTERS-1:0]                     master_sel_vec_o,
    output logic                                   granted_master_o,
    output logic [MASTERS-1:0]                     master_gnt_o,
    output logic [MASTER_BITS-1:0]                 rsp_sel_int_o,
    output logic [MASTERS-1:0]                     master_rvalid_o,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_o
);

    arb_state_e             state;
    arb_state_e             state_next;
    logic [MASTER_BITS-1:0] lock_idx;
    logic [MASTER_BITS-1:0] lock_next;
    logic [MASTER_BITS-1:0] pick_idx;
    logic [MASTER_BITS-1:0] cand_idx;
    logic                   cand_valid;
    logic [MASTERS-1:0]     dreq;
    logic                   handshake;
    logic                   rsp_pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [MASTER_BITS-1:0] fifo_head;

    // Cyclic search for the first set request at or above 'start',
    // wrapping from the top master back to master 0.
    function automatic logic [MASTER_BITS-1:0] pick_first(
        input logic [MASTERS-1:0] req,
        input int                 start
    );
        logic [MASTER_BITS-1:0] pick;
        logic                   found;
        int                     idx;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < MASTERS; k++) begin
            idx = (start + k) % MASTERS;
            if (!found && req[idx]) begin
                pick  = MASTER_BITS'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // A request only competes for this slave when its address decodes here.
    always_comb begin
        dreq = '0;
        for (int m = 0; m < MASTERS; m++) begin
            dreq[m] = master_req_i[m] &
                      ((master_addr_i[m] & slave_addr_mask_i) == slave_addr_base_i);
        end
    end

`ifdef OBI_ARB_FIXED_PRIO_EN
    // Fixed priority: the search always starts at master 0.
    assign pick_idx = pick_first(dreq, 0);
`else
    logic [MASTER_BITS-1:0] rr_ptr;

    assign pick_idx = pick_first(dreq, int'(rr_ptr));

    // After every completed handshake the search restarts just above the
    // master that was served, so each requester gets a turn. With a single
    // master this always loads zero.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr <= '0;
        end else if (handshake) begin
            rr_ptr <= (cand_idx == MASTER_BITS'(MASTERS - 1)) ?
                      '0 : cand_idx + MASTER_BITS'(1);
        end
    end
`endif

    // State and lock registers. The lock index is only meaningful while
    // locked but is kept reset to zero so its value is always defined.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= ARB_IDLE;
            lock_idx <= '0;
        end else begin
            state    <= state_next;
            lock_idx <= lock_next;
        end
    end

    // Candidate selection and next state. In idle the search result is
    // offered; if the slave does not grant it immediately, it is frozen so
    // the address phase stays stable until the grant. If the locked master
    // withdraws its request the lock is simply released and nothing is
    // recorded, since no handshake happened.
    always_comb begin
        state_next = state;
        lock_next  = lock_idx;
        cand_valid = 1'b0;
        cand_idx   = '0;
        case (state)
            ARB_IDLE: begin
                cand_valid = |dreq;
                cand_idx   = pick_idx;
                if (cand_valid && !fifo_full && !slave_gnt_i) begin
                    state_next = ARB_LOCKED;
                    lock_next  = pick_idx;
                end
            end
            ARB_LOCKED: begin
                cand_valid = dreq[lock_idx];
                cand_idx   = lock_idx;
                if (!cand_valid || (!fifo_full && slave_gnt_i)) begin
                    state_next = ARB_IDLE;
                end
            end
            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    // Address phase. The selection outputs keep showing the candidate while
    // the ID FIFO is full; only the request to the slave is held back so no
    // transaction can be granted that could not be tracked.
    assign slave_req_o      = cand_valid & ~fifo_full;
    assign handshake        = slave_req_o & slave_gnt_i;
    assign master_sel_int_o = cand_valid ? cand_idx : '0;
    assign master_sel_vec_o = cand_valid ? (MASTERS'(1) << cand_idx) : '0;
    assign granted_master_o = |master_sel_vec_o;
    assign master_gnt_o     = handshake ? master_sel_vec_o : '0;

    // Response phase. An rvalid with nothing outstanding is dropped.
    assign rsp_pop          = slave_rvalid_i & ~fifo_empty;
    assign master_rvalid_o  = rsp_pop ? (MASTERS'(1) << fifo_head) : '0;
    assign rsp_sel_int_o    = fifo_head;

    obi_arb_id_fifo #(
        .WIDTH (MASTER_BITS),
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .push      (handshake),
        .push_data (cand_idx),
        .pop       (rsp_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (outstanding_o)
    );

endmodule

// File: tb/tb_obi_rr_slave_arbiter.sv
// ============================================================================
// tb_obi_rr_slave_arbiter
// ----------------------------------------------------------------------------
// Self-checking bench for obi_rr_slave_arbiter (MASTERS=3, MAX_OUTSTANDING=2,
// slave decoded at 0x1xxx_xxxx). A transaction-level reference model (grant
// pointer, lock flag and a queue of outstanding master indices) predicts every
// output each cycle. Directed sequences are followed by randomized traffic.
// Define OBI_ARB_FIXED_PRIO_EN for both bench and RTL to check fixed priority.
// ============================================================================
module tb_obi_rr_slave_arbiter;

    localparam int          NM   = 3;
    localparam int          MAXO = 2;
    localparam logic [31:0] MASK = 32'hF000_0000;
    localparam logic [31:0] BASE = 32'h1000_0000;
`ifdef OBI_ARB_FIXED_PRIO_EN
    localparam bit FIXED_PRIO = 1'b1;
`else
    localparam bit FIXED_PRIO = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rstN;
    logic [NM-1:0]        masterReq;
    logic [NM-1:0][31:0]  masterAddr;
    logic                 slaveGnt;
    logic                 slaveRvalid;
    logic                 slaveReq;
    logic [1:0]           masterSelInt;
    logic [NM-1:0]        masterSelVec;
    logic                 grantedMaster;
    logic [NM-1:0]        masterGnt;
    logic [1:0]           rspSelInt;
    logic [NM-1:0]        masterRvalid;
    logic [1:0]           outstanding;

    int errors = 0;
    int checks = 0;

    // Reference model state
    int mRrPtr;
    bit mLocked;
    int mLockIdx;
    int mQ[$];

    // Per-cycle predictions
    bit eCandValid;
    int eCand;
    bit eReq;
    bit eHs;
    bit ePop;

    // Sampled DUT outputs for directed checks
    logic [NM-1:0] obsGnt;
    logic [NM-1:0] obsRvalid;
    logic [1:0]    obsSel;
    logic          obsReq;
    logic [1:0]    obsOut;

    int order[6] = '{0, 1, 2, 0, 1, 2};

    obi_rr_slave_arbiter #(
        .MASTERS         (NM),
        .MAX_OUTSTANDING (MAXO)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rstN),
        .master_req_i      (masterReq),
        .master_addr_i     (masterAddr),
        .slave_addr_mask_i (MASK),
        .slave_addr_base_i (BASE),
        .slave_gnt_i       (slaveGnt),
        .slave_rvalid_i    (slaveRvalid),
        .slave_req_o       (slaveReq),
        .master_sel_int_o  (masterSelInt),
        .master_sel_vec_o  (masterSelVec),
        .granted_master_o  (grantedMaster),
        .master_gnt_o      (masterGnt),
        .rsp_sel_int_o     (rspSelInt),
        .master_rvalid_o   (masterRvalid),
        .outstanding_o     (outstanding)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic resetModel();
        mRrPtr   = 0;
        mLocked  = 1'b0;
        mLockIdx = 0;
        mQ.delete();
    endtask

    // Predict this cycle's outputs from the arbitration rules.
    task automatic modelEval();
        bit dreq[NM];
        int idx;
        for (int m = 0; m < NM; m++) begin
            dreq[m] = masterReq[m] && ((masterAddr[m] & MASK) == BASE);
        end
        eCandValid = 1'b0;
        eCand      = 0;
        if (mLocked) begin
            eCandValid = dreq[mLockIdx];
            eCand      = mLockIdx;
        end else begin
            for (int k = 0; k < NM; k++) begin
                idx = FIXED_PRIO ? k : (mRrPtr + k) % NM;
                if (!eCandValid && dreq[idx]) begin
                    eCandValid = 1'b1;
                    eCand      = idx;
                end
            end
        end
        eReq = eCandValid && (mQ.size() < MAXO);
        eHs  = eReq && slaveGnt;
        ePop = slaveRvalid && (mQ.size() > 0);
    endtask

    task automatic modelUpdate();
        if (ePop) void'(mQ.pop_front());
        if (eHs) begin
            mQ.push_back(eCand);
            mRrPtr  = (eCand + 1) % NM;
            mLocked = 1'b0;
        end else if (mLocked && !eCandValid) begin
            mLocked = 1'b0;
        end else if (!mLocked && eReq && !slaveGnt) begin
            mLocked  = 1'b1;
            mLockIdx = eCand;
        end
    endtask

    // One clock: drive inputs after the falling edge, compare every output
    // against the model, then let the rising edge advance the model.
    task automatic applyStimulus(input logic [NM-1:0] req, input logic [NM-1:0] match,
                                 input logic gnt, input logic rv);
        logic [31:0] expRv;
        @(negedge clk);
        for (int m = 0; m < NM; m++) begin
            masterReq[m] = req[m];
            if (match[m])
                masterAddr[m] = {4'h1, 28'($urandom)};
            else
                masterAddr[m] = {4'(2 + $urandom_range(0, 13)), 28'($urandom)};
        end
        slaveGnt    = gnt;
        slaveRvalid = rv;
        #1;
        modelEval();
        checkOutput("slave_req", 32'(slaveReq), 32'(eReq));
        checkOutput("sel_vec", 32'(masterSelVec), eCandValid ? (32'(1) << eCand) : 32'(0));
        checkOutput("granted", 32'(grantedMaster), 32'(eCandValid));
        if (eCandValid) checkOutput("sel_int", 32'(masterSelInt), 32'(eCand));
        checkOutput("master_gnt", 32'(masterGnt), eHs ? (32'(1) << eCand) : 32'(0));
        expRv = 32'(0);
        if (ePop) expRv = 32'(1) << mQ[0];
        checkOutput("master_rvalid", 32'(masterRvalid), expRv);
        checkOutput("outstanding", 32'(outstanding), 32'(mQ.size()));
        if (mQ.size() > 0) checkOutput("rsp_sel", 32'(rspSelInt), 32'(mQ[0]));
        obsGnt    = masterGnt;
        obsRvalid = masterRvalid;
        obsSel    = masterSelInt;
        obsReq    = slaveReq;
        obsOut    = outstanding;
        @(posedge clk);
        modelUpdate();
    endtask

    task automatic checkIdleOutputs(input string tag);
        checkOutput({tag, "_req"}, 32'(slaveReq), 32'(0));
        checkOutput({tag, "_vec"}, 32'(masterSelVec), 32'(0));
        checkOutput({tag, "_granted"}, 32'(grantedMaster), 32'(0));
        checkOutput({tag, "_gnt"}, 32'(masterGnt), 32'(0));
        checkOutput({tag, "_rvalid"}, 32'(masterRvalid), 32'(0));
        checkOutput({tag, "_out"}, 32'(outstanding), 32'(0));
        checkOutput({tag, "_rsp"}, 32'(rspSelInt), 32'(0));
    endtask

    initial begin
        logic [NM-1:0] rReq;
        logic [NM-1:0] rMatch;
        rstN        = 1'b0;
        masterReq   = '0;
        masterAddr  = '0;
        slaveGnt    = 1'b0;
        slaveRvalid = 1'b0;
        resetModel();
        #1;
        checkIdleOutputs("reset");
        repeat (2) @(negedge clk);
        rstN = 1'b1;

`ifndef OBI_ARB_FIXED_PRIO_EN
        // All three masters, zero-wait grants, rvalid one cycle later
        applyStimulus(3'b111, 3'b111, 1'b1, 1'b0);
        checkOutput("rr_order", 32'(obsGnt), 32'(1) << order[0]);
        for (int i = 1; i < 6; i++) begin
            applyStimulus(3'b111, 3'b111, 1'b1, 1'b1);
            checkOutput("rr_order", 32'(obsGnt), 32'(1) << order[i]);
            checkOutput("rr_rsp", 32'(obsRvalid), 32'(1) << order[i-1]);
        end
        applyStimulus(3'b000, 3'b000, 1'b0, 1'b1);
        checkOutput("rr_rsp_last", 32'(obsRvalid), 32'(3'b100));

        // Lock on M2 while M0 joins
        applyStimulus(3'b100, 3'b111, 1'b0, 1'b0);
        checkOutput("lock_sel", 32'(obsSel), 32'(2));
        for (int i = 0; i < 3; i++) begin
            applyStimulus(3'b101, 3'b111, 1'b0, 1'b0);
            checkOutput("lock_sel", 32'(obsSel), 32'(2));
            checkOutput("lock_req", 32'(obsReq), 32'(1));
        end
        applyStimulus(3'b101, 3'b111, 1'b1, 1'b0);
        checkOutput("lock_gnt", 32'(obsGnt), 32'(3'b100));
        applyStimulus(3'b001, 3'b111, 1'b1, 1'b1);
        checkOutput("lock_next", 32'(obsGnt), 32'(3'b001));
        applyStimulus(3'b000, 3'b000, 1'b0, 1'b1);

        // Fill the ID FIFO, then free one slot
        for (int i = 0; i < 3; i++) begin
            applyStimulus(3'b010, 3'b111, 1'b1, 1'b0);
            checkOutput("full_out", 32'(obsOut), 32'(i));
            checkOutput("full_req", 32'(obsReq), (i == 2) ? 32'(0) : 32'(1));
        end
        applyStimulus(3'b010, 3'b111, 1'b1, 1'b1);
        checkOutput("full_rsp", 32'(obsRvalid), 32'(3'b010));
        checkOutput("full_blocked", 32'(obsReq), 32'(0));
        applyStimulus(3'b010, 3'b111, 1'b1, 1'b0);
        checkOutput("full_regrant", 32'(obsGnt), 32'(3'b010));
        repeat (2) applyStimulus(3'b000, 3'b000, 1'b0, 1'b1);

        // Address decode: M0 targets another slave
        applyStimulus(3'b011, 3'b010, 1'b1, 1'b0);
        checkOutput("decode_gnt", 32'(obsGnt), 32'(3'b010));
        applyStimulus(3'b000, 3'b000, 1'b0, 1'b1);
`else
        // Fixed priority: M0 wins every cycle
        applyStimulus(3'b111, 3'b111, 1'b1, 1'b0);
        checkOutput("fp_gnt", 32'(obsGnt), 32'(3'b001));
        for (int i = 0; i < 5; i++) begin
            applyStimulus(3'b111, 3'b111, 1'b1, 1'b1);
            checkOutput("fp_gnt", 32'(obsGnt), 32'(3'b001));
        end
        applyStimulus(3'b000, 3'b000, 1'b0, 1'b1);
`endif

        // Stray rvalid with nothing outstanding
        applyStimulus(3'b000, 3'b000, 1'b0, 1'b1);
        checkOutput("stray_rvalid", 32'(obsRvalid), 32'(0));
        checkOutput("stray_out", 32'(obsOut), 32'(0));

        // Asynchronous reset while locked with one outstanding
        applyStimulus(3'b100, 3'b111, 1'b1, 1'b0);
        applyStimulus(3'b010, 3'b111, 1'b0, 1'b0);
        @(negedge clk);
        slaveRvalid = 1'b0;
        #2 rstN = 1'b0;
        #1;
        checkOutput("arst_out", 32'(outstanding), 32'(0));
        checkOutput("arst_rsp", 32'(rspSelInt), 32'(0));
        masterReq = '0;
        #1;
        checkIdleOutputs("arst");
        @(negedge clk);
        rstN = 1'b1;
        resetModel();
        applyStimulus(3'b011, 3'b111, 1'b1, 1'b0);
        checkOutput("arst_unlock", 32'(obsGnt), 32'(3'b001));
        applyStimulus(3'b000, 3'b000, 1'b0, 1'b1);

        // Randomized traffic with sticky requests so locks persist
        rReq   = '0;
        rMatch = 3'b111;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) begin
                rReq   = 3'($urandom);
                rMatch = 3'($urandom) | 3'($urandom);
            end
            applyStimulus(rReq, rMatch, 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 2) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
